// File: rtl/crc_pkg.sv
// Shared definitions for the parametrised CRC engine:
// register map, field positions, transpose helpers, FIFO entry and FSM types.
package crc_pkg;

  localparam logic [31:0] OFF_DATA   = 32'h0;
  localparam logic [31:0] OFF_GPOLY  = 32'h4;
  localparam logic [31:0] OFF_CTRL   = 32'h8;
  localparam logic [31:0] OFF_STATUS = 32'hC;

  localparam int CTRL_TOT_LSB  = 30;
  localparam int CTRL_TOTR_LSB = 28;
  localparam int CTRL_FXOR     = 26;
  localparam int CTRL_WAS      = 25;
  localparam int CTRL_DSZ_LSB  = 22;
  localparam int CTRL_IRQ_EN   = 0;

  localparam int ST_BUSY = 0;
  localparam int ST_FULL = 1;
  localparam int ST_OVF  = 2;
  localparam int ST_IRQ  = 4;

  typedef enum logic [1:0] {
    TP_NONE    = 2'b00,
    TP_BITREV8 = 2'b01,
    TP_REV32   = 2'b10,
    TP_BSWAP   = 2'b11
  } tp_code_t;

  typedef struct packed {
    logic        seed;
    logic [1:0]  dsz;
    logic [31:0] data;
  } crc_entry_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } crc_state_t;

  function automatic logic [31:0] transpose32(
    input logic [31:0] d,
    input logic [1:0]  code
  );
    logic [31:0] r;
    r = d;
    unique case (tp_code_t'(code))
      TP_NONE: r = d;
      TP_BITREV8: begin
        for (int b = 0; b < 4; b++)
          for (int i = 0; i < 8; i++)
            r[8*b+i] = d[8*b+7-i];
      end
      TP_REV32: begin
        for (int i = 0; i < 32; i++)
          r[i] = d[31-i];
      end
      TP_BSWAP: r = {d[7:0], d[15:8], d[23:16], d[31:24]};
    endcase
    return r;
  endfunction

  // DSZ code 11 is treated like 00 (full word).
  function automatic logic [5:0] dsz_bits(input logic [1:0] dsz);
    logic [5:0] n;
    unique case (dsz)
      2'b01:   n = 6'd16;
      2'b10:   n = 6'd8;
      default: n = 6'd32;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/crc_engine_param_fifo.sv
// Input queue for the CRC engine: synchronous FIFO of crc_entry_t.
// Pushes while full are refused here; the caller flags the overflow.
module crc_in_fifo
  import crc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  crc_entry_t din,
  output crc_entry_t dout,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  crc_entry_t  mem_q [DEPTH];
  logic [AW:0] wp_q, wp_d;
  logic [AW:0] rp_q, rp_d;
  logic        do_push, do_pop;

  assign full  = (wp_q[AW] != rp_q[AW]) &&
                 (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign empty = (wp_q == rp_q);
  assign dout  = mem_q[rp_q[AW-1:0]];

  // Pointer advance; full/empty judged on the current occupancy.
  always_comb begin
    do_push = push && !full;
    do_pop  = pop && !empty;
    wp_d    = do_push ? wp_q + 1'b1 : wp_q;
    rp_d    = do_pop ? rp_q + 1'b1 : rp_q;
  end

  // Pointer registers, flushed by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  end

  // Storage array; contents need no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/crc_engine_param.sv
// Memory-mapped CRC engine: register decode, queued input, BPC-wide fold.
// Optional completion interrupt enabled by defining CRC_IRQ_EN.
module crc_engine_param
  import crc_pkg::*;
#(
  parameter int          CRC_W      = 32,
  parameter int          BPC        = 8,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h4003_2000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Sel,
  input  logic        RW,
  input  logic [31:0] addr,
  input  logic [31:0] data_wr,
  output logic [31:0] data_rd
`ifdef CRC_IRQ_EN
  ,
  output logic        irq
`endif
);

`ifdef CRC_IRQ_EN
  localparam logic [31:0] CTRL_MASK = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] CTRL_MASK = 32'hFFFF_FFFE;
`endif

  logic [CRC_W-1:0] crc_q, crc_d;
  logic [CRC_W-1:0] poly_q, poly_d;
  logic [31:0]      gpoly_q, gpoly_d;
  logic [31:0]      ctrl_q, ctrl_d;
  logic [31:0]      sh_q, sh_d;
  logic [5:0]       rem_q, rem_d;
  crc_state_t       state_q, state_d;
  logic             ovf_q, ovf_d;
  logic             irq_pend_q, irq_pend_d;

  logic             wr, rd;
  logic             hit_data, hit_gpoly, hit_ctrl, hit_status;
  logic             push, pop, full, empty, busy;
  crc_entry_t       in_ent, head;
  logic [CRC_W-1:0] c, r_crc;
  logic [31:0]      s, r_ext;
  logic             fb;

  assign wr         = Sel && RW;
  assign rd         = Sel && !RW;
  assign hit_data   = (addr == BASE_ADDR + OFF_DATA);
  assign hit_gpoly  = (addr == BASE_ADDR + OFF_GPOLY);
  assign hit_ctrl   = (addr == BASE_ADDR + OFF_CTRL);
  assign hit_status = (addr == BASE_ADDR + OFF_STATUS);
  assign push       = wr && hit_data;
  assign busy       = !empty || (state_q == SHIFT);

  assign in_ent.seed = ctrl_q[CTRL_WAS];
  assign in_ent.dsz  = ctrl_q[CTRL_DSZ_LSB +: 2];
  assign in_ent.data = transpose32(data_wr, ctrl_q[CTRL_TOT_LSB +: 2]);

  crc_in_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (in_ent),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

`ifdef CRC_IRQ_EN
  logic busy_q;

  // Previous busy level, for completion edge detection.
  always_ff @(posedge clk) begin
    if (rst) busy_q <= 1'b0;
    else     busy_q <= busy;
  end

  assign irq = irq_pend_q;
`endif

  // Register writes and sticky status; a set beats a same-cycle clear.
  always_comb begin
    gpoly_d = gpoly_q;
    ctrl_d  = ctrl_q;
    ovf_d   = ovf_q;
    if (wr && hit_gpoly) gpoly_d = data_wr;
    if (wr && hit_ctrl)  ctrl_d  = data_wr & CTRL_MASK;
    if (wr && hit_status && data_wr[ST_OVF]) ovf_d = 1'b0;
    if (push && full) ovf_d = 1'b1;
`ifdef CRC_IRQ_EN
    irq_pend_d = irq_pend_q;
    if (wr && hit_status && data_wr[ST_IRQ]) irq_pend_d = 1'b0;
    if (busy_q && !busy && ctrl_q[CTRL_IRQ_EN]) irq_pend_d = 1'b1;
`else
    irq_pend_d = 1'b0;
`endif
  end

  // Engine: pop in IDLE, then fold up to BPC bits per clock, MSB first.
  always_comb begin
    crc_d   = crc_q;
    poly_d  = poly_q;
    sh_d    = sh_q;
    rem_d   = rem_q;
    state_d = state_q;
    pop     = 1'b0;
    c       = crc_q;
    s       = sh_q;
    fb      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          if (head.seed) begin
            crc_d = head.data[CRC_W-1:0];
          end else begin
            poly_d  = gpoly_q[CRC_W-1:0];
            rem_d   = dsz_bits(head.dsz);
            sh_d    = head.data << (6'd32 - rem_d);
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        for (int i = 0; i < BPC; i++) begin
          if (i < int'(rem_q)) begin
            fb = c[CRC_W-1] ^ s[31];
            c  = {c[CRC_W-2:0], 1'b0} ^ (fb ? poly_q : '0);
            s  = {s[30:0], 1'b0};
          end
        end
        crc_d   = c;
        sh_d    = s;
        rem_d   = (rem_q > 6'(BPC)) ? rem_q - 6'(BPC) : 6'd0;
        state_d = (rem_d == 6'd0) ? IDLE : SHIFT;
      end
    endcase
  end

  // State and register update.
  always_ff @(posedge clk) begin
    if (rst) begin
      crc_q      <= '1;
      poly_q     <= '0;
      gpoly_q    <= 32'h0000_1021;
      ctrl_q     <= '0;
      sh_q       <= '0;
      rem_q      <= '0;
      state_q    <= IDLE;
      ovf_q      <= 1'b0;
      irq_pend_q <= 1'b0;
    end else begin
      crc_q      <= crc_d;
      poly_q     <= poly_d;
      gpoly_q    <= gpoly_d;
      ctrl_q     <= ctrl_d;
      sh_q       <= sh_d;
      rem_q      <= rem_d;
      state_q    <= state_d;
      ovf_q      <= ovf_d;
      irq_pend_q <= irq_pend_d;
    end
  end

  // Read mux; DATA shows the live remainder, even mid-word.
  always_comb begin
    r_crc   = ctrl_q[CTRL_FXOR] ? ~crc_q : crc_q;
    r_ext   = '0;
    r_ext[CRC_W-1:0] = r_crc;
    data_rd = '0;
    if (rd) begin
      unique case (1'b1)
        hit_data:
          data_rd = transpose32(r_ext, ctrl_q[CTRL_TOTR_LSB +: 2]);
        hit_gpoly:  data_rd = gpoly_q;
        hit_ctrl:   data_rd = ctrl_q;
        hit_status:
          data_rd = {27'b0, irq_pend_q, 1'b0, ovf_q, full, busy};
        default:    data_rd = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_crc_engine_param.sv
// Directed bench for crc_engine_param: three instances cover 16/32-bit
// widths and BPC=1 for the overflow case.
module tb_crc_engine_param;

  localparam logic [31:0] BA  = 32'h4003_2000;
  localparam logic [31:0] A_D = BA + 32'h0;
  localparam logic [31:0] A_P = BA + 32'h4;
  localparam logic [31:0] A_C = BA + 32'h8;
  localparam logic [31:0] A_S = BA + 32'hC;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  sel = '0;
  logic        rw = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] dwr = '0;
  logic [31:0] rd0, rd1, rd2;
`ifdef CRC_IRQ_EN
  logic        irq0, irq1, irq2;
`endif

  int checks = 0;
  int failures = 0;
  logic [31:0] v;

  always #5 clk = ~clk;

  crc_engine_param #(.CRC_W(16), .BPC(8), .FIFO_DEPTH(4), .BASE_ADDR(BA)) u16 (
    .clk(clk), .rst(rst), .Sel(sel[0]), .RW(rw), .addr(addr),
    .data_wr(dwr), .data_rd(rd0)
`ifdef CRC_IRQ_EN
    , .irq(irq0)
`endif
  );

  crc_engine_param #(.CRC_W(32), .BPC(8), .FIFO_DEPTH(4), .BASE_ADDR(BA)) u32 (
    .clk(clk), .rst(rst), .Sel(sel[1]), .RW(rw), .addr(addr),
    .data_wr(dwr), .data_rd(rd1)
`ifdef CRC_IRQ_EN
    , .irq(irq1)
`endif
  );

  crc_engine_param #(.CRC_W(16), .BPC(1), .FIFO_DEPTH(4), .BASE_ADDR(BA)) u1 (
    .clk(clk), .rst(rst), .Sel(sel[2]), .RW(rw), .addr(addr),
    .data_wr(dwr), .data_rd(rd2)
`ifdef CRC_IRQ_EN
    , .irq(irq2)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] m, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    sel = m; rw = 1'b1; addr = a; dwr = d;
    @(posedge clk);
    #1;
    sel = '0; rw = 1'b0;
  endtask

  task automatic rd(input logic [2:0] m, input logic [31:0] a, output logic [31:0] val);
    @(negedge clk);
    sel = m; rw = 1'b0; addr = a;
    #1;
    val = m[0] ? rd0 : (m[1] ? rd1 : rd2);
    sel = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic wait_idle(input logic [2:0] m, input string tag);
    logic [31:0] st;
    st = 32'h1;
    for (int k = 0; k < 400 && st[0]; k++) rd(m, A_S, st);
    chk(tag, {31'b0, st[0]}, 32'h0);
  endtask

  // "123456789" one byte per write, with a spare cycle so the queue stays shallow.
  task automatic send_check_string(input logic [2:0] m);
    for (int i = 0; i < 9; i++) begin
      wr(m, A_D, 32'h31 + i);
      idle(1);
    end
  endtask

  initial begin
    // Test 1: reset values after junk writes
    idle(2);
    @(negedge clk) rst = 1'b0;
    wr(3'b111, A_P, 32'hDEAD_BEEF);
    wr(3'b111, A_C, 32'h0600_0000);
    wr(3'b111, A_D, 32'h0000_1234);
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    rd(3'b001, A_P, v); chk("rst_gpoly", v, 32'h0000_1021);
    rd(3'b001, A_C, v); chk("rst_ctrl", v, 32'h0);
    rd(3'b001, A_S, v); chk("rst_status", v, 32'h0);
    rd(3'b001, A_D, v); chk("rst_data", v, 32'h0000_FFFF);
    rd(3'b001, BA + 32'h10, v); chk("unmapped_rd", v, 32'h0);

    // Test 2: CRC-16/CCITT-FALSE over "123456789", DSZ=8
    wr(3'b001, A_C, 32'h0080_0000);
    wr(3'b001, A_D, 32'h0000_0030 + 32'h1);
    rd(3'b001, A_S, v); chk("busy_after_wr", v & 32'h1, 32'h1);
    for (int i = 1; i < 9; i++) begin
      wr(3'b001, A_D, 32'h31 + i);
      idle(1);
    end
    wait_idle(3'b001, "t2_idle");
    rd(3'b001, A_D, v); chk("crc16_ccitt", v, 32'h0000_29B1);

`ifdef CRC_IRQ_EN
    wr(3'b001, A_C, 32'h0080_0001);
    wr(3'b001, A_D, 32'h0000_0041);
    wait_idle(3'b001, "irq_idle");
    idle(2);
    chk("irq_set", {31'b0, irq0}, 32'h1);
    rd(3'b001, A_S, v); chk("irq_pend", v & 32'h10, 32'h10);
    wr(3'b001, A_S, 32'h10);
    #1 chk("irq_clr", {31'b0, irq0}, 32'h0);
`endif

    // Test 3: CRC-32 (reflected in/out, final XOR)
    wr(3'b010, A_P, 32'h04C1_1DB7);
    wr(3'b010, A_C, 32'h6480_0000);
    rd(3'b010, A_P, v); chk("gpoly_rb", v, 32'h04C1_1DB7);
    rd(3'b010, A_C, v); chk("ctrl_rb", v, 32'h6480_0000);
    send_check_string(3'b010);
    wait_idle(3'b010, "t3_idle");
    rd(3'b010, A_D, v); chk("crc32", v, 32'hCBF4_3926);

    // Test 4a: seed then rerun
    wr(3'b010, A_C, 32'h6680_0000);
    wr(3'b010, A_D, 32'hFFFF_FFFF);
    wr(3'b010, A_C, 32'h6480_0000);
    send_check_string(3'b010);
    wait_idle(3'b010, "t4a_idle");
    rd(3'b010, A_D, v); chk("crc32_seed", v, 32'hCBF4_3926);

    // Test 4b: seed queued behind data words
    wr(3'b010, A_D, 32'h0000_00AA);
    wr(3'b010, A_D, 32'h0000_0055);
    wr(3'b010, A_D, 32'h0000_00C3);
    wr(3'b010, A_C, 32'h6680_0000);
    wr(3'b010, A_D, 32'hFFFF_FFFF);
    wr(3'b010, A_C, 32'h6480_0000);
    send_check_string(3'b010);
    wait_idle(3'b010, "t4b_idle");
    rd(3'b010, A_D, v); chk("crc32_seed_order", v, 32'hCBF4_3926);
    rd(3'b010, A_S, v); chk("t4_no_ovf", v & 32'h4, 32'h0);

    // Test 5: overflow on BPC=1; dropped word must not disturb the CRC
    wr(3'b100, A_C, 32'h0080_0000);
    for (int i = 0; i < 5; i++) wr(3'b100, A_D, 32'h31 + i);
    wr(3'b100, A_D, 32'h0000_00AA);
    rd(3'b100, A_S, v); chk("ovf_set", v & 32'h6, 32'h6);
    wr(3'b100, A_S, 32'h4);
    rd(3'b100, A_S, v); chk("ovf_w1c", v & 32'h4, 32'h0);
    wait_idle(3'b100, "t5a_idle");
    for (int i = 5; i < 9; i++) wr(3'b100, A_D, 32'h31 + i);
    wait_idle(3'b100, "t5b_idle");
    rd(3'b100, A_D, v); chk("ovf_crc", v, 32'h0000_29B1);

    // Test 6: reset mid-word
    wr(3'b001, A_C, 32'h0000_0001);
    wr(3'b001, A_D, 32'hA5A5_A5A5);
    idle(2);
    rd(3'b001, A_S, v); chk("t6_busy", v & 32'h1, 32'h1);
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    rd(3'b001, A_S, v); chk("t6_status", v, 32'h0);
    rd(3'b001, A_D, v); chk("t6_data", v, 32'h0000_FFFF);
`ifdef CRC_IRQ_EN
    idle(3);
    chk("t6_irq", {31'b0, irq0}, 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
